// File: rtl/prs_decim_if.sv
// Result handshake bundle for the prs_decim bitstream decimator.
interface prs_decim_if #(
   parameter int unsigned OUT_W = 8
);
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prs_decim.sv
// prs_decim: counts ones over 2^WINDOW_LOG2 enabled samples of a PRS
// bitstream and presents the ones-density as an OUT_W-bit word with a
// valid/ready handshake and a sticky overrun flag.
module prs_decim #(
   parameter int unsigned WINDOW_LOG2 = 8,
   parameter int unsigned OUT_W       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bit_in,
   input  logic        bit_en,
   prs_decim_if.master result,
   output logic        overrun
);

   localparam int unsigned SHIFT = WINDOW_LOG2 - OUT_W;
   localparam logic [WINDOW_LOG2:0] RES_MAX =
      {{(WINDOW_LOG2 + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
   localparam logic [WINDOW_LOG2-1:0] CNT_ONE =
      {{(WINDOW_LOG2 - 1){1'b0}}, 1'b1};

   logic [WINDOW_LOG2-1:0] smp_cnt;
   logic [WINDOW_LOG2:0]   acc;
   logic [WINDOW_LOG2:0]   sum;
   logic [WINDOW_LOG2:0]   shifted;
   logic [OUT_W-1:0]       res_word;
   logic                   win_close;

   // Window-close detection, ones sum and saturated result word.
   always_comb begin
      win_close = bit_en && (smp_cnt == '1);
      sum       = acc + {{WINDOW_LOG2{1'b0}}, bit_in};
      shifted   = sum >> SHIFT;
      res_word  = (shifted > RES_MAX) ? '1 : shifted[OUT_W-1:0];
   end

   // Sample counting, result load and output handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         smp_cnt          <= '0;
         acc              <= '0;
         result.out_data  <= '0;
         result.out_valid <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         if (win_close) begin
            smp_cnt          <= '0;
            acc              <= '0;
            result.out_data  <= res_word;
            result.out_valid <= 1'b1;
            // Overwriting an unconsumed word that is not taken this edge.
            if (result.out_valid && !result.out_ready) begin
               overrun <= 1'b1;
            end
         end else begin
            if (bit_en) begin
               smp_cnt <= smp_cnt + CNT_ONE;
               acc     <= sum;
            end
            if (result.out_valid && result.out_ready) begin
               result.out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_prs_decim.sv
// Directed self-checking bench for prs_decim with default parameters.
module tb_prs_decim;

   logic clk;
   logic reset;
   logic bit_in;
   logic bit_en;
   logic overrun;

   int errors;
   int checks;

   prs_decim_if #(.OUT_W(8)) bus ();

   prs_decim #(.WINDOW_LOG2(8), .OUT_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .bit_in  (bit_in),
      .bit_en  (bit_en),
      .result  (bus.master),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic b, input logic en);
      bit_in = b;
      bit_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b1, 1'b1);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] lfsr;
      int         diff;
      errors       = 0;
      checks       = 0;
      reset        = 1'b1;
      bit_in       = 1'b0;
      bit_en       = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("rst_data", {24'd0, bus.out_data}, 32'h0);
      check("rst_valid", {31'd0, bus.out_valid}, 32'h0);
      check("rst_ovr", {31'd0, overrun}, 32'h0);
      reset = 1'b0;

      // Constant ones: saturated result, one-cycle valid pulse
      for (int i = 0; i < 255; i++) step(1'b1, 1'b1);
      check("ones_pre_close", {31'd0, bus.out_valid}, 32'h0);
      step(1'b1, 1'b1);
      check("ones_valid", {31'd0, bus.out_valid}, 32'h1);
      check("ones_data", {24'd0, bus.out_data}, 32'hFF);
      step(1'b1, 1'b1);
      check("ones_consumed", {31'd0, bus.out_valid}, 32'h0);
      check("ones_hold", {24'd0, bus.out_data}, 32'hFF);
      for (int i = 0; i < 254; i++) step(1'b1, 1'b1);
      check("ones2_pre_close", {31'd0, bus.out_valid}, 32'h0);
      step(1'b1, 1'b1);
      check("ones2_valid", {31'd0, bus.out_valid}, 32'h1);
      check("ones2_data", {24'd0, bus.out_data}, 32'hFF);
      check("ones2_ovr", {31'd0, overrun}, 32'h0);

      // Alternating 0,1 every cycle: half density
      do_reset();
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 256; i++) step(1'(i & 1), 1'b1);
         check("alt_valid", {31'd0, bus.out_valid}, 32'h1);
         check("alt_data", {24'd0, bus.out_data}, 32'h80);
      end

      // Constant zeros
      for (int i = 0; i < 256; i++) step(1'b0, 1'b1);
      check("zero_valid", {31'd0, bus.out_valid}, 32'h1);
      check("zero_data", {24'd0, bus.out_data}, 32'h00);

      // Enable every other cycle; disabled cycles carry 1s that must be ignored
      do_reset();
      for (int i = 0; i < 510; i++) step((i % 2 == 0) ? 1'((i / 2) & 1) : 1'b1, (i % 2 == 0));
      check("en2_pre_close", {31'd0, bus.out_valid}, 32'h0);
      step(1'b1, 1'b1);  // enabled sample 255 (odd index -> 1)
      check("en2_valid", {31'd0, bus.out_valid}, 32'h1);
      check("en2_data", {24'd0, bus.out_data}, 32'h80);

      // Overrun: ready held low over two windows
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) step(1'b1, 1'b1);
      check("ovr1_valid", {31'd0, bus.out_valid}, 32'h1);
      check("ovr1_data", {24'd0, bus.out_data}, 32'hFF);
      check("ovr1_flag", {31'd0, overrun}, 32'h0);
      for (int i = 0; i < 256; i++) step(1'b1, 1'b1);
      check("ovr2_valid", {31'd0, bus.out_valid}, 32'h1);
      check("ovr2_data", {24'd0, bus.out_data}, 32'hFF);
      check("ovr2_flag", {31'd0, overrun}, 32'h1);
      bus.out_ready = 1'b1;
      step(1'b1, 1'b0);
      check("ovr_consume_valid", {31'd0, bus.out_valid}, 32'h0);
      check("ovr_sticky", {31'd0, overrun}, 32'h1);

      // Reset at sample 100 of a window discards the partial window
      for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
      do_reset();
      check("mid_rst_data", {24'd0, bus.out_data}, 32'h0);
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'h0);
      check("mid_rst_ovr", {31'd0, overrun}, 32'h0);
      for (int i = 0; i < 255; i++) step(1'b1, 1'b1);
      check("mid_pre_close", {31'd0, bus.out_valid}, 32'h0);
      step(1'b1, 1'b1);
      check("mid_valid", {31'd0, bus.out_valid}, 32'h1);
      check("mid_data", {24'd0, bus.out_data}, 32'hFF);

      // Loopback from a maximal-length 8-bit LFSR PRS DAC driven with 0x80
      do_reset();
      lfsr = 8'h01;
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < 256; i++) begin
            step((lfsr < 8'h80), 1'b1);
            lfsr = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
         end
         check("prs_valid", {31'd0, bus.out_valid}, 32'h1);
         diff = int'(bus.out_data) - 128;
         check("prs_within_2lsb", {31'd0, (diff >= -2 && diff <= 2)}, 32'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
